// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a byte FIFO behind a ready/valid port feeds a
// serializer that starts the next frame on the same edge the previous stop bit ends.
module uart_tx_buffered #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          serial_out,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              serial_q, serial_d;
    logic              push, pop, baud_done;

    assign data_in_ready = (count_q != CNT_FULL);
    assign push          = data_in_valid && data_in_ready;
    assign baud_done     = (baud_q == BAUD_LAST);

    always_comb begin
        pop       = 1'b0;
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        case (state_q)
            ST_IDLE: begin
                serial_d = 1'b1;
                baud_d   = '0;
                if (count_q != '0) pop = 1'b1;
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d    = '0;
                    serial_d  = shift_q[0];
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        serial_d = 1'b1;
                        state_d  = ST_STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        serial_d  = shift_q[1];
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (count_q != '0) pop = 1'b1;
                    else               state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase

        // A pop always launches a start bit, whether from IDLE or straight out of STOP.
        if (pop) begin
            shift_d   = mem[head_q];
            serial_d  = 1'b0;
            state_d   = ST_START;
            baud_d    = '0;
            bit_idx_d = 3'd0;
            head_d    = head_q + 1'b1;
        end
        if (push) tail_d = tail_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[tail_q] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
        end
    end

    assign serial_out = serial_q;
    assign fifo_count = count_q;
    assign tx_busy    = (state_q != ST_IDLE) || (count_q != '0);
endmodule
